// File: rtl/sm_mem_stream_tester.sv
// ============================================================================
// Module   : sm_mem_stream_tester
// Brief    : Self-checking memory traffic generator. Writes a seeded pattern
//            to consecutive words, reads it back and counts mismatches.
//            Optional macro SM_MEM_STREAM_TESTER_RANDGAP_EN adds LFSR-driven
//            request/response bubbles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SM_MEM_LEN_NBITS
`define SM_MEM_LEN_NBITS(d) (((d) > 8) ? $clog2((d)/8) : 1)
`endif
`ifndef SM_MEM_REQ_MSG_NBITS
`define SM_MEM_REQ_MSG_NBITS(o,a,d) (1 + (o) + (a) + `SM_MEM_LEN_NBITS(d) + (d))
`endif
`ifndef SM_MEM_RESP_MSG_NBITS
`define SM_MEM_RESP_MSG_NBITS(o,d) (1 + (o) + `SM_MEM_LEN_NBITS(d) + (d))
`endif

module sm_mem_stream_tester #(
    parameter int          p_opaque_nbits = 8,
    parameter int          p_addr_nbits   = 32,
    parameter int          p_data_nbits   = 32,
    parameter int          p_num_words    = 16,
    parameter int unsigned p_base_addr    = 32'h0000_0000,
    parameter int unsigned p_seed         = 32'h0000_1000,
    parameter int          p_max_inflight = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    output logic memreq_val,
    input  logic memreq_rdy,
    output logic [`SM_MEM_REQ_MSG_NBITS(p_opaque_nbits,p_addr_nbits,p_data_nbits)-1:0] memreq_msg,
    input  logic memresp_val,
    output logic memresp_rdy,
    input  logic [`SM_MEM_RESP_MSG_NBITS(p_opaque_nbits,p_data_nbits)-1:0] memresp_msg,
    output logic done,
    output logic pass,
    output logic [15:0] num_errors
);

    localparam int c_len_nbits   = `SM_MEM_LEN_NBITS(p_data_nbits);
    localparam int c_word_bytes  = p_data_nbits / 8;
    localparam int c_last_index  = p_num_words - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_WDRAIN = 3'd2,
        ST_READ   = 3'd3,
        ST_RDRAIN = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t      r_state;
    logic [31:0] r_issue_idx;
    logic [31:0] r_resp_idx;
    logic [3:0]  r_inflight;
    logic [15:0] r_num_errors;
    logic [3:0]  w_inflight_next;
    logic        w_req_gap;
    logic        w_resp_gap;

`ifdef SM_MEM_STREAM_TESTER_RANDGAP_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_req_gap  = (r_lfsr[1:0] == 2'b00);
    assign w_resp_gap = (r_lfsr[3:2] == 2'b00);
`else
    assign w_req_gap  = 1'b0;
    assign w_resp_gap = 1'b0;
`endif

    logic w_write_phase;
    logic w_req_fire;
    logic w_resp_fire;
    logic w_last_issue;

    assign w_write_phase = (r_state == ST_WRITE) || (r_state == ST_WDRAIN);
    assign memreq_val    = ((r_state == ST_WRITE) || (r_state == ST_READ)) &&
                           (r_inflight < 4'(p_max_inflight)) && !w_req_gap;
    assign memresp_rdy   = (r_state != ST_IDLE) && (r_state != ST_DONE) && !w_resp_gap;
    assign w_req_fire    = memreq_val && memreq_rdy;
    assign w_resp_fire   = memresp_val && memresp_rdy;
    assign w_last_issue  = (r_issue_idx == 32'(c_last_index));

    // Request fields derive only from registered index/state, so the message
    // holds steady for as long as the memory back-pressures.
    logic                      w_req_type;
    logic [p_addr_nbits-1:0]   w_req_addr;
    logic [p_data_nbits-1:0]   w_req_data;

    assign w_req_type = (r_state == ST_WRITE);
    assign w_req_addr = p_addr_nbits'(p_base_addr) +
                        p_addr_nbits'(r_issue_idx) * p_addr_nbits'(c_word_bytes);
    assign w_req_data = w_req_type ? (p_data_nbits'(p_seed) + p_data_nbits'(r_issue_idx))
                                   : '0;
    assign memreq_msg = {w_req_type, r_issue_idx[p_opaque_nbits-1:0], w_req_addr,
                         c_len_nbits'(0), w_req_data};

    logic                      w_resp_type;
    logic [p_opaque_nbits-1:0] w_resp_opaque;
    logic [c_len_nbits-1:0]    w_resp_len;
    logic [p_data_nbits-1:0]   w_resp_data;
    logic                      w_unused_resp_len;
    logic                      w_resp_bad;

    assign {w_resp_type, w_resp_opaque, w_resp_len, w_resp_data} = memresp_msg;
    assign w_unused_resp_len = ^w_resp_len;

    // A response with nothing outstanding is itself an error; all faults on
    // one response collapse into a single count.
    assign w_resp_bad = (w_resp_type != w_write_phase) ||
                        (w_resp_opaque != r_resp_idx[p_opaque_nbits-1:0]) ||
                        (!w_write_phase &&
                         (w_resp_data != p_data_nbits'(p_seed) + p_data_nbits'(r_resp_idx))) ||
                        (r_inflight == 4'd0);

    always_comb begin
        w_inflight_next = r_inflight;
        if (w_req_fire && !(w_resp_fire && r_inflight != 4'd0)) begin
            w_inflight_next = r_inflight + 4'd1;
        end else if (!w_req_fire && w_resp_fire && r_inflight != 4'd0) begin
            w_inflight_next = r_inflight - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_issue_idx  <= '0;
            r_resp_idx   <= '0;
            r_inflight   <= '0;
            r_num_errors <= '0;
        end else begin
            if (w_resp_fire) begin
                r_resp_idx <= r_resp_idx + 32'd1;
                if (w_resp_bad && r_num_errors != 16'hFFFF) begin
                    r_num_errors <= r_num_errors + 16'd1;
                end
            end
            if (w_req_fire) begin
                r_issue_idx <= r_issue_idx + 32'd1;
            end
            r_inflight <= w_inflight_next;

            // Later assignments here take priority over the updates above.
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        r_state      <= ST_WRITE;
                        r_num_errors <= '0;
                        r_issue_idx  <= '0;
                        r_resp_idx   <= '0;
                        r_inflight   <= '0;
                    end
                end
                ST_WRITE: begin
                    if (w_req_fire && w_last_issue) r_state <= ST_WDRAIN;
                end
                ST_WDRAIN: begin
                    if (r_inflight == 4'd0) begin
                        r_state     <= ST_READ;
                        r_issue_idx <= '0;
                        r_resp_idx  <= '0;
                    end
                end
                ST_READ: begin
                    if (w_req_fire && w_last_issue) r_state <= ST_RDRAIN;
                end
                ST_RDRAIN: begin
                    if (r_inflight == 4'd0) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done       = (r_state == ST_DONE);
    assign pass       = done && (r_num_errors == 16'd0);
    assign num_errors = r_num_errors;

endmodule

`default_nettype wire

// File: tb/tb_sm_mem_stream_tester.sv
// ============================================================================
// Module   : tb_sm_mem_stream_tester
// Brief    : Three tester instances on a shared word memory with per-port
//            in-order response delay; request stream is scoreboarded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_mem_stream_tester;

    localparam int NP     = 3;
    localparam int REQ_W  = 75;   // type[74] opaque[73:66] addr[65:34] len[33:32] data[31:0]
    localparam int RESP_W = 43;   // type[42] opaque[41:34] len[33:32] data[31:0]

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              go       [NP];
    logic              req_val  [NP];
    logic              req_rdy  [NP];
    logic [REQ_W-1:0]  req_msg  [NP];
    logic              resp_val [NP];
    logic              resp_rdy [NP];
    logic [RESP_W-1:0] resp_msg [NP];
    logic              done     [NP];
    logic              pass     [NP];
    logic [15:0]       nerr     [NP];

    sm_mem_stream_tester u_dut0 (
        .clk(clk), .reset(reset), .go(go[0]),
        .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]), .memreq_msg(req_msg[0]),
        .memresp_val(resp_val[0]), .memresp_rdy(resp_rdy[0]), .memresp_msg(resp_msg[0]),
        .done(done[0]), .pass(pass[0]), .num_errors(nerr[0])
    );

    sm_mem_stream_tester #(.p_base_addr(32'h200), .p_seed(32'h2000)) u_dut1 (
        .clk(clk), .reset(reset), .go(go[1]),
        .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]), .memreq_msg(req_msg[1]),
        .memresp_val(resp_val[1]), .memresp_rdy(resp_rdy[1]), .memresp_msg(resp_msg[1]),
        .done(done[1]), .pass(pass[1]), .num_errors(nerr[1])
    );

    sm_mem_stream_tester #(.p_max_inflight(1)) u_dut2 (
        .clk(clk), .reset(reset), .go(go[2]),
        .memreq_val(req_val[2]), .memreq_rdy(req_rdy[2]), .memreq_msg(req_msg[2]),
        .memresp_val(resp_val[2]), .memresp_rdy(resp_rdy[2]), .memresp_msg(resp_msg[2]),
        .done(done[2]), .pass(pass[2]), .num_errors(nerr[2])
    );

    logic [31:0]      mem [256];
    int               max_delay [NP];
    bit               stall     [NP];
    bit               drop3     [NP];
    int               infl      [NP];
    int               max_infl  [NP];
    int               nreq      [NP];
    bit               seen_read [NP];
    int unsigned      base_addr [NP];
    int unsigned      seed      [NP];
    int               run_cyc   [NP];
    logic [REQ_W-1:0] sb_q      [NP][$];
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RESP_W-1:0] msg;
        int                t;
    } resp_t;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] exp_req(input int p, input int i, input bit wr);
        logic [31:0] a;
        logic [31:0] d;
        a = base_addr[p] + 32'(i) * 32'd4;
        d = wr ? (seed[p] + 32'(i)) : 32'h0;
        return {wr, 8'(i), a, 2'b00, d};
    endfunction

    // Memory port model: inputs settle at the falling edge; fires decided
    // here are the ones the next rising edge will sample.
    for (genvar p = 0; p < NP; p++) begin : g_mem
        resp_t rq[$];
        int    last_t;
        initial begin
            bit               fr;
            bit               fs;
            resp_t            r;
            int               w;
            logic [31:0]      a;
            logic [REQ_W-1:0] e;
            req_rdy[p]  = 1'b1;
            resp_val[p] = 1'b0;
            resp_msg[p] = '0;
            last_t      = 0;
            forever begin
                @(negedge clk);
                req_rdy[p] = !stall[p];
                if (reset) begin
                    rq.delete();
                    last_t      = 0;
                    infl[p]     = 0;
                    resp_val[p] = 1'b0;
                    resp_msg[p] = '0;
                end else begin
                    if (rq.size() > 0 && rq[0].t <= cyc) begin
                        resp_val[p] = 1'b1;
                        resp_msg[p] = rq[0].msg;
                    end else begin
                        resp_val[p] = 1'b0;
                    end
                    fr = req_val[p] && req_rdy[p];
                    fs = resp_val[p] && resp_rdy[p];
                    if (fs) void'(rq.pop_front());
                    if (fr) begin
                        e = '1;
                        if (sb_q[p].size() > 0) e = sb_q[p].pop_front();
                        check($sformatf("req_msg_p%0d", p), req_msg[p], e);
                        a = req_msg[p][65:34];
                        w = int'(a[9:2]);
                        if (req_msg[p][74]) begin
                            if (!(drop3[p] && w == 3)) mem[w] = req_msg[p][31:0];
                            r.msg = {1'b1, req_msg[p][73:66], 2'b00, 32'h0};
                        end else begin
                            r.msg = {1'b0, req_msg[p][73:66], 2'b00, mem[w]};
                            seen_read[p] = 1'b1;
                        end
                        r.t = cyc + 1 + int'($urandom_range(max_delay[p], max_delay[p] / 2));
                        if (r.t < last_t) r.t = last_t;
                        last_t = r.t;
                        rq.push_back(r);
                        nreq[p]++;
                    end
                    infl[p] += (fr ? 1 : 0) - (fs ? 1 : 0);
                    if (infl[p] > max_infl[p]) max_infl[p] = infl[p];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input bit [NP-1:0] mask);
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) begin
                for (int i = 0; i < 16; i++) sb_q[p].push_back(exp_req(p, i, 1'b1));
                for (int i = 0; i < 16; i++) sb_q[p].push_back(exp_req(p, i, 1'b0));
                max_infl[p]  = 0;
                seen_read[p] = 1'b0;
                go[p]        = 1'b1;
            end
        end
        tick();
        for (int p = 0; p < NP; p++) go[p] = 1'b0;
    endtask

    task automatic finish(input bit [NP-1:0] mask, input int exp_err);
        int n = 0;
        bit all;
        for (int p = 0; p < NP; p++) run_cyc[p] = -1;
        while (n < 3000) begin
            all = 1'b1;
            for (int p = 0; p < NP; p++) begin
                if (mask[p] && run_cyc[p] < 0) begin
                    if (done[p]) run_cyc[p] = n;
                    else all = 1'b0;
                end
            end
            if (all) break;
            tick();
            n++;
        end
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) begin
                check($sformatf("done_p%0d", p), done[p], 1'b1);
                check($sformatf("num_errors_p%0d", p), nerr[p], 16'(exp_err));
                check($sformatf("pass_p%0d", p), pass[p], (exp_err == 0));
                check($sformatf("sb_left_p%0d", p), sb_q[p].size(), 0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_val"}, req_val[0], 1'b0);
        check({tag, "_rdy"}, resp_rdy[0], 1'b0);
        check({tag, "_done"}, done[0], 1'b0);
        check({tag, "_pass"}, pass[0], 1'b0);
        check({tag, "_nerr"}, nerr[0], 16'h0);
    endtask

    initial begin
        int  n;
        int  base;
        bit  hit;
        reset = 1'b1;
        for (int p = 0; p < NP; p++) begin
            go[p] = 1'b0; stall[p] = 1'b0; drop3[p] = 1'b0; max_delay[p] = 0;
            infl[p] = 0; max_infl[p] = 0; nreq[p] = 0; seen_read[p] = 1'b0;
            base_addr[p] = 32'h0; seed[p] = 32'h1000;
        end
        base_addr[1] = 32'h200;
        seed[1]      = 32'h2000;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Zero-delay memory, single run
        launch(3'b001);
        finish(3'b001, 0);
        check("zd_latency_window", (run_cyc[0] >= 30 && run_cyc[0] <= 42), 1'b1);
        check("mem_word5", mem[5], 32'h1005);

        // Delayed memory: inflight limit 4 vs 1
        max_delay[0] = 8;
        max_delay[2] = 8;
        launch(3'b101);
        finish(3'b101, 0);
        check("max_inflight_p0", max_infl[0], 4);
        check("max_inflight_p2", max_infl[2], 1);
        check("inflight4_faster", (run_cyc[0] < run_cyc[2]), 1'b1);

        // Word 3 write dropped, stale value left behind
        max_delay[0] = 0;
        mem[3]       = 32'hDEAD;
        drop3[0]     = 1'b1;
        launch(3'b001);
        finish(3'b001, 1);
        drop3[0] = 1'b0;

        // Request back-pressure for 10 cycles mid-write
        base = nreq[0];
        launch(3'b001);
        n = 0;
        while (nreq[0] < base + 5 && n < 200) begin
            tick();
            n++;
        end
        check("stall_reached", (nreq[0] >= base + 5), 1'b1);
        stall[0] = 1'b1;
        repeat (10) begin
            tick();
            check("stall_msg", req_msg[0], (sb_q[0].size() > 0) ? sb_q[0][0] : {REQ_W{1'b1}});
        end
        stall[0] = 1'b0;
        finish(3'b001, 0);

        // Reset during reads with two requests outstanding
        max_delay[0] = 8;
        launch(3'b001);
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 1000) begin
            tick();
            n++;
            hit = seen_read[0] && (infl[0] == 2);
        end
        check("read_inflight2_reached", hit, 1'b1);
        reset = 1'b1;
        tick();
        check_reset_outputs("midrun_reset");
        reset = 1'b0;
        sb_q[0].delete();
        tick();
        launch(3'b001);
        finish(3'b001, 0);

        // Both memory ports concurrently
        max_delay[0] = 6;
        max_delay[1] = 6;
        launch(3'b011);
        finish(3'b011, 0);
        check("mem_port1_word5", mem[128 + 5], 32'h2005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
